// File: rtl/fm0_pkg.sv
// Shared definitions for the FM0 receive path: command lengths, CRC-16 constants,
// the sequencer state encoding and the bit-serial CRC step.
package fm0_pkg;

   localparam int          RX_MAX_BITS = 96;
   localparam logic [15:0] T_PRE_DEF   = 16'd4000;
   localparam logic [15:0] T_BIT_DEF   = 16'd512;
   localparam logic [15:0] T_DONE_DEF  = 16'd1024;

   localparam logic [5:0]  CMD_NO_CRC  = 6'd3;

   localparam logic [15:0] CRC_POLY    = 16'h1021;
   localparam logic [15:0] CRC_PRESET  = 16'hFFFF;
   localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARM       = 3'd1,
      ST_RECV      = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_REPORT    = 3'd4
   } rx_state_t;

   // Reply length in bits for the command the reply answers; 0 means no reply.
   function automatic logic [6:0] exp_len(input logic [5:0] cmd);
      logic [6:0] len;
      case (cmd)
         6'd3:                                   len = 7'd16;
         6'd2:                                   len = 7'd66;
         6'd7,  6'd8,  6'd14, 6'd15, 6'd16,
         6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
         6'd33, 6'd34, 6'd36, 6'd37, 6'd38,
         6'd39:                                  len = 7'd40;
         6'd23, 6'd24, 6'd25, 6'd40:             len = 7'd78;
         6'd9,  6'd10:                           len = 7'd94;
         6'd30, 6'd31, 6'd32, 6'd35:             len = 7'd24;
         default:                                len = 7'd0;
      endcase
      return len;
   endfunction

   function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic bit_in);
      logic fb;
      fb = crc[15] ^ bit_in;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/fm0_rx_ctrl_if.sv
// Command/result and decoder-side signals of the FM0 receive sequencer.
// master = protocol controller plus decoder side, slave = fm0_rx_ctrl.
interface fm0_rx_ctrl_if
   import fm0_pkg::*;
#(
   parameter int MAX_BITS = RX_MAX_BITS
);
   logic                rx_start;
   logic [5:0]          rx_cmd;
   logic                rx_abort;
   logic                fm0_start;
   logic                fm0_clk;
   logic                fm0_data;
   logic                fm0_done;
   logic                fm0_en;
   logic [5:0]          cmd_head;
   logic [MAX_BITS-1:0] rx_data;
   logic [6:0]          rx_len;
   logic                rx_valid;
   logic                rx_crc_ok;
   logic                rx_timeout;
   logic                busy;

   modport master (
      output rx_start, rx_cmd, rx_abort, fm0_start, fm0_clk, fm0_data, fm0_done,
      input  fm0_en, cmd_head, rx_data, rx_len, rx_valid, rx_crc_ok, rx_timeout, busy
   );

   modport slave (
      input  rx_start, rx_cmd, rx_abort, fm0_start, fm0_clk, fm0_data, fm0_done,
      output fm0_en, cmd_head, rx_data, rx_len, rx_valid, rx_crc_ok, rx_timeout, busy
   );
endinterface

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16/CCITT register, MSB first; shared by the receive and transmit paths.
module crc16_serial
   import fm0_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_preset,
   input  logic        i_en,
   input  logic        i_data,
   output logic [15:0] o_crc
);

   logic [15:0] r_crc;

   // Preset takes priority over a same-cycle data bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_crc <= CRC_PRESET;
      end else if (i_preset) begin
         r_crc <= CRC_PRESET;
      end else if (i_en) begin
         r_crc <= crc16_next(r_crc, i_data);
      end else begin
         r_crc <= r_crc;
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/fm0_rx_ctrl.sv
// FM0 reply receive sequencer: arms the decoder, supervises preamble/bit/done
// timeouts, assembles the reply word and reports it with its CRC verdict.
module fm0_rx_ctrl
   import fm0_pkg::*;
#(
   parameter int          MAX_BITS = RX_MAX_BITS,
   parameter logic [15:0] T_PRE    = T_PRE_DEF,
   parameter logic [15:0] T_BIT    = T_BIT_DEF,
   parameter logic [15:0] T_DONE   = T_DONE_DEF
) (
   input  logic         base_clk,
   input  logic         rst,
   fm0_rx_ctrl_if.slave bus
);

   // Decoder inputs: [0],[1] synchronize, [2] holds the previous value for edge detection.
   logic [2:0]          r_start_sync;
   logic [2:0]          r_clk_sync;
   logic [2:0]          r_done_sync;
   logic [1:0]          r_data_sync;

   rx_state_t           r_state;
   logic [15:0]         r_timer;
   logic [6:0]          r_exp_len;
   logic [6:0]          r_rx_len;
   logic [MAX_BITS-1:0] r_rx_data;
   logic [5:0]          r_cmd_head;
   logic                r_fm0_en;
   logic                r_rx_valid;
   logic                r_rx_crc_ok;
   logic                r_rx_timeout;
   logic                r_busy;
   logic                r_to_flag;

   logic                w_start_ev;
   logic                w_clk_ev;
   logic                w_done_ev;
   logic                w_bit_take;
   logic                w_crc_preset;
   logic                w_no_crc;
   logic [15:0]         w_crc;

   assign w_start_ev   = r_start_sync[1] & ~r_start_sync[2];
   assign w_clk_ev     = r_clk_sync[1]   & ~r_clk_sync[2];
   assign w_done_ev    = r_done_sync[1]  & ~r_done_sync[2];
   assign w_bit_take   = (r_state == ST_RECV) && w_clk_ev && !bus.rx_abort
                         && (r_rx_len < r_exp_len);
   assign w_crc_preset = (r_state == ST_IDLE) && bus.rx_start;
   assign w_no_crc     = (r_cmd_head == CMD_NO_CRC) || (r_exp_len == 7'd0);

   // Two-flop synchronizers for the decoder outputs.
   always_ff @(posedge base_clk) begin
      if (rst) begin
         r_start_sync <= 3'd0;
         r_clk_sync   <= 3'd0;
         r_done_sync  <= 3'd0;
         r_data_sync  <= 2'd0;
      end else begin
         r_start_sync <= {r_start_sync[1:0], bus.fm0_start};
         r_clk_sync   <= {r_clk_sync[1:0],   bus.fm0_clk};
         r_done_sync  <= {r_done_sync[1:0],  bus.fm0_done};
         r_data_sync  <= {r_data_sync[0],    bus.fm0_data};
      end
   end

   crc16_serial u_crc (
      .clk      (base_clk),
      .rst      (rst),
      .i_preset (w_crc_preset),
      .i_en     (w_bit_take),
      .i_data   (r_data_sync[1]),
      .o_crc    (w_crc)
   );

   // Sequencer; fm0_en lags the state by one cycle so it drops together with rx_valid.
   always_ff @(posedge base_clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_timer      <= 16'd0;
         r_exp_len    <= 7'd0;
         r_rx_len     <= 7'd0;
         r_rx_data    <= {MAX_BITS{1'b0}};
         r_cmd_head   <= 6'd0;
         r_fm0_en     <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_rx_crc_ok  <= 1'b0;
         r_rx_timeout <= 1'b0;
         r_busy       <= 1'b0;
         r_to_flag    <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_fm0_en   <= (r_state == ST_ARM) || (r_state == ST_RECV) || (r_state == ST_WAIT_DONE);
         case (r_state)
            ST_IDLE: begin
               if (bus.rx_start) begin
                  r_cmd_head <= bus.rx_cmd;
                  r_exp_len  <= exp_len(bus.rx_cmd);
                  r_rx_data  <= {MAX_BITS{1'b0}};
                  r_rx_len   <= 7'd0;
                  r_timer    <= 16'd0;
                  r_to_flag  <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= (exp_len(bus.rx_cmd) == 7'd0) ? ST_REPORT : ST_ARM;
               end
            end
            ST_ARM: begin
               if (bus.rx_abort) begin
                  r_to_flag <= 1'b1;
                  r_state   <= ST_REPORT;
               end else if (w_start_ev) begin
                  r_timer <= 16'd0;
                  r_state <= ST_RECV;
               end else if (r_timer == T_PRE - 16'd1) begin
                  r_to_flag <= 1'b1;
                  r_state   <= ST_REPORT;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            ST_RECV: begin
               if (bus.rx_abort) begin
                  r_to_flag <= 1'b1;
                  r_state   <= ST_REPORT;
               end else if (w_clk_ev) begin
                  r_timer <= 16'd0;
                  if (w_bit_take) begin
                     r_rx_data <= {r_rx_data[MAX_BITS-2:0], r_data_sync[1]};
                     r_rx_len  <= r_rx_len + 7'd1;
                     if (r_rx_len + 7'd1 == r_exp_len) begin
                        r_state <= ST_WAIT_DONE;
                     end
                  end
               end else if (r_timer == T_BIT - 16'd1) begin
                  r_to_flag <= 1'b1;
                  r_state   <= ST_REPORT;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            ST_WAIT_DONE: begin
               if (bus.rx_abort) begin
                  r_to_flag <= 1'b1;
                  r_state   <= ST_REPORT;
               end else if (w_done_ev) begin
                  r_state <= ST_REPORT;
               end else if (r_timer == T_DONE - 16'd1) begin
                  r_to_flag <= 1'b1;
                  r_state   <= ST_REPORT;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            ST_REPORT: begin
               r_rx_valid   <= 1'b1;
               r_rx_timeout <= r_to_flag;
               r_rx_crc_ok  <= !r_to_flag && (w_no_crc || (w_crc == CRC_RESIDUE));
               r_busy       <= 1'b0;
               r_state      <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.fm0_en     = r_fm0_en;
   assign bus.cmd_head   = r_cmd_head;
   assign bus.rx_data    = r_rx_data;
   assign bus.rx_len     = r_rx_len;
   assign bus.rx_valid   = r_rx_valid;
   assign bus.rx_crc_ok  = r_rx_crc_ok;
   assign bus.rx_timeout = r_rx_timeout;
   assign bus.busy       = r_busy;

endmodule

// File: tb/tb_fm0_rx_ctrl.sv
// Directed self-checking bench for fm0_rx_ctrl: RN16, CRC replies, timeouts, abort, reset.
module tb_fm0_rx_ctrl;

   logic base_clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   fm0_rx_ctrl_if bus ();

   fm0_rx_ctrl dut (
      .base_clk (base_clk),
      .rst      (rst),
      .bus      (bus)
   );

   initial base_clk = 1'b0;
   always #5 base_clk = ~base_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge base_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_cmd(input logic [5:0] cmd);
      bus.rx_cmd   = cmd;
      bus.rx_start = 1'b1;
      step();
      bus.rx_start = 1'b0;
   endtask

   task automatic pulse_start();
      bus.fm0_start = 1'b1;
      repeat (3) step();
      bus.fm0_start = 1'b0;
      repeat (2) step();
   endtask

   task automatic send_bit(input logic b, input int period);
      bus.fm0_data = b;
      bus.fm0_clk  = 1'b1;
      repeat (4) step();
      bus.fm0_clk  = 1'b0;
      repeat (period - 4) step();
   endtask

   task automatic send_bits(input logic [95:0] v, input int nbits, input int period);
      for (int i = nbits - 1; i >= 0; i--) send_bit(v[i], period);
   endtask

   task automatic wait_valid(input string tag, input int max, output int n);
      n = 0;
      while (!bus.rx_valid && n < max) begin
         step();
         n++;
      end
      check(tag, bus.rx_valid, 1'b1);
   endtask

   function automatic logic [15:0] ref_crc(input logic [23:0] d);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 23; i >= 0; i--) begin
         fb = c[15] ^ d[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   initial begin
      int          n;
      logic [23:0] payload;
      logic [39:0] frame;
      logic [39:0] bad_frame;
      logic [38:0] pat;

      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bus.rx_start = 1'b0; bus.rx_cmd = 6'd0; bus.rx_abort = 1'b0;
      bus.fm0_start = 1'b0; bus.fm0_clk = 1'b0; bus.fm0_data = 1'b0; bus.fm0_done = 1'b0;
      repeat (2) step();
      check("rst_fm0_en", bus.fm0_en, 1'b0);
      check("rst_cmd_head", bus.cmd_head, 6'd0);
      check("rst_rx_valid", bus.rx_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_rx_len", bus.rx_len, 7'd0);
      rst = 1'b0;
      step();

      // RN16 reply, no CRC, exact done-to-valid latency
      start_cmd(6'd3);
      check("rn16_busy", bus.busy, 1'b1);
      check("rn16_cmd_head", bus.cmd_head, 6'd3);
      check("rn16_en_lag", bus.fm0_en, 1'b0);
      step();
      check("rn16_en", bus.fm0_en, 1'b1);
      pulse_start();
      send_bits(96'hA5C3, 16, 100);
      bus.fm0_done = 1'b1;
      repeat (3) step();
      check("rn16_valid_early", bus.rx_valid, 1'b0);
      step();
      check("rn16_valid", bus.rx_valid, 1'b1);
      check("rn16_data", bus.rx_data, 96'hA5C3);
      check("rn16_len", bus.rx_len, 7'd16);
      check("rn16_crc_ok", bus.rx_crc_ok, 1'b1);
      check("rn16_timeout", bus.rx_timeout, 1'b0);
      check("rn16_en_off", bus.fm0_en, 1'b0);
      bus.fm0_done = 1'b0;
      step();
      check("rn16_valid_once", bus.rx_valid, 1'b0);
      repeat (3) step();
      check("rn16_data_hold", bus.rx_data, 96'hA5C3);
      check("rn16_len_hold", bus.rx_len, 7'd16);

      // 24 data bits plus complemented CRC-16: good, then one bit flipped
      payload   = 24'hABCDEF;
      frame     = {payload, ~ref_crc(payload)};
      bad_frame = frame;
      bad_frame[20] = ~bad_frame[20];
      start_cmd(6'd7);
      step();
      pulse_start();
      send_bits({56'd0, frame}, 40, 20);
      bus.fm0_done = 1'b1;
      wait_valid("crc_good_wait", 20, n);
      bus.fm0_done = 1'b0;
      check("crc_good_len", bus.rx_len, 7'd40);
      check("crc_good_data", bus.rx_data, {56'd0, frame});
      check("crc_good_ok", bus.rx_crc_ok, 1'b1);
      check("crc_good_to", bus.rx_timeout, 1'b0);
      step();
      start_cmd(6'd7);
      step();
      pulse_start();
      send_bits({56'd0, bad_frame}, 40, 20);
      bus.fm0_done = 1'b1;
      wait_valid("crc_bad_wait", 20, n);
      bus.fm0_done = 1'b0;
      check("crc_bad_len", bus.rx_len, 7'd40);
      check("crc_bad_ok", bus.rx_crc_ok, 1'b0);
      check("crc_bad_to", bus.rx_timeout, 1'b0);
      step();

      // Preamble timeout: rx_valid T_PRE cycles after fm0_en rises
      start_cmd(6'd9);
      step();
      check("pre_en", bus.fm0_en, 1'b1);
      repeat (3999) step();
      check("pre_valid_early", bus.rx_valid, 1'b0);
      check("pre_en_still", bus.fm0_en, 1'b1);
      step();
      check("pre_valid", bus.rx_valid, 1'b1);
      check("pre_en_off", bus.fm0_en, 1'b0);
      check("pre_timeout", bus.rx_timeout, 1'b1);
      check("pre_crc_ok", bus.rx_crc_ok, 1'b0);
      check("pre_len", bus.rx_len, 7'd0);
      step();

      // Inter-bit timeout after 10 of 24 bits
      start_cmd(6'd30);
      step();
      pulse_start();
      send_bits(96'h155, 9, 20);
      bus.fm0_data = 1'b0;
      bus.fm0_clk  = 1'b1;
      wait_valid("bit_to_wait", 600, n);
      check("bit_to_latency", n, 516);
      check("bit_to_len", bus.rx_len, 7'd10);
      check("bit_to_data", bus.rx_data, 96'h2AA);
      check("bit_to_timeout", bus.rx_timeout, 1'b1);
      check("bit_to_crc_ok", bus.rx_crc_ok, 1'b0);
      bus.fm0_clk = 1'b0;
      step();

      // Abort coinciding with the 40th bit event
      pat = 39'h35A5C3F0E1;
      start_cmd(6'd23);
      step();
      pulse_start();
      send_bits({57'd0, pat}, 39, 20);
      bus.fm0_data = 1'b1;
      bus.fm0_clk  = 1'b1;
      step();
      step();
      check("abort_len_pre", bus.rx_len, 7'd39);
      bus.rx_abort = 1'b1;
      step();
      bus.rx_abort = 1'b0;
      check("abort_valid_early", bus.rx_valid, 1'b0);
      step();
      check("abort_valid", bus.rx_valid, 1'b1);
      check("abort_len", bus.rx_len, 7'd39);
      check("abort_data", bus.rx_data, {57'd0, pat});
      check("abort_timeout", bus.rx_timeout, 1'b1);
      check("abort_crc_ok", bus.rx_crc_ok, 1'b0);
      bus.fm0_clk = 1'b0;
      step();

      // Reset in the middle of RECV
      start_cmd(6'd23);
      step();
      pulse_start();
      send_bits(96'h16, 5, 20);
      check("mid_busy", bus.busy, 1'b1);
      check("mid_len", bus.rx_len, 7'd5);
      rst = 1'b1;
      step();
      check("mid_rst_en", bus.fm0_en, 1'b0);
      check("mid_rst_cmd", bus.cmd_head, 6'd0);
      check("mid_rst_data", bus.rx_data, 96'd0);
      check("mid_rst_len", bus.rx_len, 7'd0);
      check("mid_rst_valid", bus.rx_valid, 1'b0);
      check("mid_rst_crc_ok", bus.rx_crc_ok, 1'b0);
      check("mid_rst_to", bus.rx_timeout, 1'b0);
      check("mid_rst_busy", bus.busy, 1'b0);
      rst = 1'b0;
      step();

      // Command with no reply: report two cycles after rx_start
      start_cmd(6'd1);
      check("n0_busy", bus.busy, 1'b1);
      check("n0_en_a", bus.fm0_en, 1'b0);
      check("n0_valid_early", bus.rx_valid, 1'b0);
      step();
      check("n0_valid", bus.rx_valid, 1'b1);
      check("n0_crc_ok", bus.rx_crc_ok, 1'b1);
      check("n0_timeout", bus.rx_timeout, 1'b0);
      check("n0_en_b", bus.fm0_en, 1'b0);
      check("n0_busy_off", bus.busy, 1'b0);
      step();

      // rx_start while busy is ignored; abort in ARM; abort in IDLE is harmless
      start_cmd(6'd9);
      start_cmd(6'd2);
      check("busy_cmd_head", bus.cmd_head, 6'd9);
      check("busy_still", bus.busy, 1'b1);
      bus.rx_abort = 1'b1;
      step();
      bus.rx_abort = 1'b0;
      step();
      check("arm_abort_valid", bus.rx_valid, 1'b1);
      check("arm_abort_to", bus.rx_timeout, 1'b1);
      check("arm_abort_crc", bus.rx_crc_ok, 1'b0);
      bus.rx_abort = 1'b1;
      step();
      bus.rx_abort = 1'b0;
      step();
      check("idle_abort_valid", bus.rx_valid, 1'b0);
      check("idle_abort_busy", bus.busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
